// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath widths, register-file state encoding and ALU control codes.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    typedef enum logic {
        RF_RUN     = 1'b0,
        RF_HALTED  = 1'b1
    } rf_state_e;

    // ALU control encodings shared with RISCVALU
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

endpackage

// File: rtl/riscv_regfile_rdport.sv
// One combinational read port: x0 / range masking and, with REGFILE_BYPASS_EN, write-first forwarding.
module riscv_regfile_rdport #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0]           addr,
    input  logic [NREGS-1:0][XLEN-1:0]  regs,
    input  logic                        commit,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [XLEN-1:0]             wr_data,
    output logic [XLEN-1:0]             data
);

    always_comb begin
        data = '0;
        if (addr != '0 && 32'(addr) < NREGS) begin
            data = regs[addr];
`ifdef REGFILE_BYPASS_EN
            // commit already excludes x0, HALTED and reset, so forwarding needs no extra gating
            if (commit && addr == wr_addr)
                data = wr_data;
`endif
        end
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_byp;
    assign unused_byp = ^{commit, wr_addr, wr_data};
`endif

endmodule

// File: rtl/riscv_regfile.sv
// Integer register file x0..x31 with RUN/HALTED write gating and a saturating commit counter.
// Optional macro: REGFILE_BYPASS_EN (write-first read ports); default build is read-first.
module riscv_regfile #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [XLEN-1:0]   rd_data,
    input  logic              last_instr_flag_in,
    output logic              halted,
    output logic [15:0]       wr_count
);

    import riscv_pkg::*;

    logic [NREGS-1:0][XLEN-1:0] regs;
    rf_state_e                  state;
    logic                       commit;

    // reset is folded in so the bypass path is also inert while reset is held
    assign commit = reset && we && (state == RF_RUN) &&
                    (rd_addr != '0) && (32'(rd_addr) < NREGS);
    assign halted = (state == RF_HALTED);

    always_ff @(posedge clk) begin
        if (!reset) begin
            regs     <= '0;
            state    <= RF_RUN;
            wr_count <= '0;
        end else begin
            if (commit) begin
                regs[rd_addr] <= rd_data;
                if (wr_count != 16'hFFFF)
                    wr_count <= wr_count + 16'd1;
            end
            if (state == RF_RUN && last_instr_flag_in)
                state <= RF_HALTED;
        end
    end

`ifdef SIMULATION
    always @(posedge clk) begin
        if (commit)
            $display("[RF] x%0d <= %h", rd_addr, rd_data);
        if (reset && state == RF_RUN && last_instr_flag_in)
            $display("[RF] HALTED");
    end
`endif

    riscv_regfile_rdport #(.XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W)) u_rd1 (
        .addr    (rs1_addr),
        .regs    (regs),
        .commit  (commit),
        .wr_addr (rd_addr),
        .wr_data (rd_data),
        .data    (rs1_data)
    );

    riscv_regfile_rdport #(.XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W)) u_rd2 (
        .addr    (rs2_addr),
        .regs    (regs),
        .commit  (commit),
        .wr_addr (rd_addr),
        .wr_data (rd_data),
        .data    (rs2_data)
    );

endmodule

// File: tb/tb_riscv_regfile.sv
// Directed bench for riscv_regfile; expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_riscv_regfile;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0, rd_addr = '0;
    logic [31:0] rs1_data, rs2_data, rd_data = '0;
    logic        we = 1'b0, last_instr_flag_in = 1'b0;
    logic        halted;
    logic [15:0] wr_count;

    int errors = 0;
    int checks = 0;

    riscv_regfile dut (
        .clk                (clk),
        .reset              (reset),
        .rs1_addr           (rs1_addr),
        .rs2_addr           (rs2_addr),
        .rs1_data           (rs1_data),
        .rs2_data           (rs2_data),
        .we                 (we),
        .rd_addr            (rd_addr),
        .rd_data            (rd_data),
        .last_instr_flag_in (last_instr_flag_in),
        .halted             (halted),
        .wr_count           (wr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; rd_addr = a; rd_data = d;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; tick(); tick();
        reset = 1'b1;
        write(5'd1, 32'hFF);
        write(5'd2, 32'hEE);
        // reset must win over a simultaneous write
        reset = 1'b0; we = 1'b1; rd_addr = 5'd3; rd_data = 32'h55;
        tick(); tick();
        reset = 1'b1; we = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++;
        if (wr_count !== 16'd0) begin errors++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
            #1;
            checks++;
            if (rs1_data !== 32'd0) begin errors++; $display("FAIL reset_rs1 x%0d got=%h exp=0", i, rs1_data); end
            checks++;
            if (rs2_data !== 32'd0) begin errors++; $display("FAIL reset_rs2 x%0d got=%h exp=0", 31 - i, rs2_data); end
        end
    endtask

    task automatic test_write_read();
        write(5'd5, 32'hDEADBEEF);
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        checks++;
        if (rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_rs1 got=%h exp=deadbeef", rs1_data); end
        checks++;
        if (rs2_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_rs2 got=%h exp=deadbeef", rs2_data); end
        checks++;
        if (wr_count !== 16'd1) begin errors++; $display("FAIL wr_rd_count got=%0d exp=1", wr_count); end
    endtask

    task automatic test_x0();
        we = 1'b1; rd_addr = 5'd0; rd_data = 32'h1234;
        rs1_addr = 5'd0;
        #1;
        checks++;
        if (rs1_data !== 32'd0) begin errors++; $display("FAIL x0_bypass got=%h exp=0", rs1_data); end
        tick();
        we = 1'b0; rs2_addr = 5'd0;
        #1;
        checks++;
        if (rs2_data !== 32'd0) begin errors++; $display("FAIL x0_read got=%h exp=0", rs2_data); end
        checks++;
        if (wr_count !== 16'd1) begin errors++; $display("FAIL x0_count got=%0d exp=1", wr_count); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_during;
        write(5'd7, 32'h1);
        we = 1'b1; rd_addr = 5'd7; rd_data = 32'hA5A5A5A5;
        rs1_addr = 5'd7; rs2_addr = 5'd5;
`ifdef REGFILE_BYPASS_EN
        exp_during = 32'hA5A5A5A5;
`else
        exp_during = 32'h1;
`endif
        #1;
        checks++;
        if (rs1_data !== exp_during) begin errors++; $display("FAIL same_cycle_during got=%h exp=%h", rs1_data, exp_during); end
        checks++;
        if (rs2_data !== 32'hDEADBEEF) begin errors++; $display("FAIL same_cycle_other got=%h exp=deadbeef", rs2_data); end
        tick();
        we = 1'b0;
        #1;
        checks++;
        if (rs1_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL same_cycle_after got=%h exp=a5a5a5a5", rs1_data); end
        checks++;
        if (wr_count !== 16'd3) begin errors++; $display("FAIL same_cycle_count got=%0d exp=3", wr_count); end
    endtask

    task automatic test_halt();
        we = 1'b1; rd_addr = 5'd3; rd_data = 32'd9; last_instr_flag_in = 1'b1;
        rs1_addr = 5'd3;
        #1;
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL halt_before got=%b exp=0", halted); end
        tick();
        we = 1'b0; last_instr_flag_in = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got=%b exp=1", halted); end
        checks++;
        if (rs1_data !== 32'd9) begin errors++; $display("FAIL halt_final_write got=%h exp=9", rs1_data); end
        checks++;
        if (wr_count !== 16'd4) begin errors++; $display("FAIL halt_count got=%0d exp=4", wr_count); end
        // writes while halted are dropped and must not forward either
        we = 1'b1; rd_addr = 5'd3; rd_data = 32'd10;
        #1;
        checks++;
        if (rs1_data !== 32'd9) begin errors++; $display("FAIL halt_no_bypass got=%h exp=9", rs1_data); end
        tick();
        we = 1'b0;
        #1;
        checks++;
        if (rs1_data !== 32'd9) begin errors++; $display("FAIL halt_ignored got=%h exp=9", rs1_data); end
        checks++;
        if (wr_count !== 16'd4) begin errors++; $display("FAIL halt_count_hold got=%0d exp=4", wr_count); end
        reset = 1'b0; tick(); reset = 1'b1;
        #1;
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL halt_exit got=%b exp=0", halted); end
        checks++;
        if (rs1_data !== 32'd0) begin errors++; $display("FAIL halt_exit_reg got=%h exp=0", rs1_data); end
        write(5'd3, 32'd10);
        checks++;
        if (rs1_data !== 32'd10) begin errors++; $display("FAIL halt_rerun got=%h exp=a", rs1_data); end
    endtask

    task automatic test_saturation();
        reset = 1'b0; tick(); reset = 1'b1;
        we = 1'b1; rd_addr = 5'd1; rs1_addr = 5'd1;
        for (int i = 0; i < 65540; i++) begin
            rd_data = 32'(i);
            tick();
        end
        checks++;
        if (wr_count !== 16'hFFFF) begin errors++; $display("FAIL sat_count got=%h exp=ffff", wr_count); end
        checks++;
        if (rs1_data !== 32'd65539) begin errors++; $display("FAIL sat_last_data got=%h exp=10003", rs1_data); end
        reset = 1'b0;
        tick();
        checks++;
        if (wr_count !== 16'd0) begin errors++; $display("FAIL sat_reset_count got=%0d exp=0", wr_count); end
        checks++;
        if (rs1_data !== 32'd0) begin errors++; $display("FAIL sat_reset_reg got=%h exp=0", rs1_data); end
        reset = 1'b1;
        rd_data = 32'h77; tick();
        rd_data = 32'h78; tick();
        rd_data = 32'h79; tick();
        we = 1'b0;
        #1;
        checks++;
        if (wr_count !== 16'd3) begin errors++; $display("FAIL sat_resume_count got=%0d exp=3", wr_count); end
        checks++;
        if (rs1_data !== 32'h79) begin errors++; $display("FAIL sat_resume_data got=%h exp=79", rs1_data); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_x0();
        test_same_cycle();
        test_halt();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
